// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide opcodes, sequencer states and iteration count.
package cpu_pkg;

  typedef enum logic [1:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX
  } md_state_t;

  localparam int unsigned MD_ITERS = 32;

  function automatic logic md_is_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO unit: 32-step shift-add multiply and restoring divide on operand
// magnitudes, with sign fix-up in a final cycle and a divide-by-zero flag.
module mult_div_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mdop,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divzero
);

  localparam logic [4:0] LastIter = 5'(MD_ITERS - 1);

  md_state_t   state_q;
  md_op_t      op_q;
  logic [63:0] acc_q;
  logic [31:0] opb_q;
  logic [4:0]  cnt_q;
  logic        neg_res_q, neg_rem_q, zero_q;
  logic        busy_q, done_q, divzero_q;
  logic [31:0] hi_q, lo_q;

  md_op_t      req_op;
  logic        req_signed, req_zero;
  logic [31:0] a_mag, b_mag;
  logic        op_div;
  logic [32:0] add_a, add_b, sum;
  logic        fits;
  logic [63:0] mul_next, div_next, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    req_op     = md_op_t'(mdop);
    req_signed = md_is_signed(req_op);
    req_zero   = md_is_div(req_op) && (srcb == 32'd0);
    a_mag      = (req_signed && srca[31]) ? -srca : srca;
    b_mag      = (req_signed && srcb[31]) ? -srcb : srcb;

    // One 33-bit adder: add multiplicand for MULT, subtract divisor (a + ~b + 1) for DIV.
    op_div = md_is_div(op_q);
    add_a  = op_div ? {1'b0, acc_q[62:31]} : {1'b0, acc_q[63:32]};
    add_b  = op_div ? ~{1'b0, opb_q} : {1'b0, opb_q};
    sum    = add_a + add_b + {32'd0, op_div};

    mul_next = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    // A bit shifted out of the remainder means it already exceeds any 32-bit divisor.
    fits     = acc_q[63] | ~sum[32];
    div_next = fits ? {sum[31:0], acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[31:0] : acc_q[31:0];
    rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MULT;
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MD_IDLE: begin
          if (start) begin
            op_q      <= req_op;
            acc_q     <= {32'd0, a_mag};
            opb_q     <= b_mag;
            cnt_q     <= '0;
            neg_res_q <= req_signed && (srca[31] ^ srcb[31]);
            neg_rem_q <= req_signed && srca[31];
            zero_q    <= req_zero;
            divzero_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= req_zero ? MD_FIX : MD_CALC;
          end
        end
        MD_CALC: begin
          acc_q <= op_div ? div_next : mul_next;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LastIter) state_q <= MD_FIX;
        end
        MD_FIX: begin
          if (zero_q) begin
            divzero_q <= 1'b1;
          end else if (op_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign divzero = divzero_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide responder for the MIPS multicycle CPU. The control unit issues MULT/MULTU/DIV/DIVU requests with rs/rt operands. This block runs a 32-iteration shift-add or restoring-divide sequence and returns the 64-bit result as hi/lo, the values behind the CPU's HI/LO registers. Divide-by-zero is flagged so the control unit can take the exception path (EPC capture).

## Interface
Parameters:
- none; width and iteration count are fixed by package constants (32-bit data, MD_ITERS = 32).

Ports:
- clock  input  1  system clock; rising-edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- start  input  1  request strobe; sampled only when busy = 0.
- mdop  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srca  input  32  operand A (rs value), sampled with start.
- srcb  input  32  operand B (rt value), sampled with start.
- busy  output  1  operation in flight; start is ignored while high.
- done  output  1  one-cycle pulse; hi/lo/divzero valid from this cycle.
- hi  output  32  MULT: upper product word. DIV: remainder.
- lo  output  32  MULT: lower product word. DIV: quotient.
- divzero  output  1  set with done when DIV/DIVU has srcb = 0; cleared on next accepted start.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start = 1:
  - Latch mdop and the operands.
  - For signed ops, convert operands to magnitudes. Record the result sign (A xor B) and the remainder sign (sign of A).
  - Clear the iteration counter, clear divzero, go to CALC.
- IDLE, start = 1, divide op with srcb = 0: go directly to FIX with the zero flag recorded.
- CALC multiply: 64-bit accumulator, one shift-add per cycle. If the LSB of the multiplier is 1, add the multiplicand into the upper half, then shift right with carry-in.
- CALC divide: restoring division on the {remainder, dividend} 64-bit register. Each cycle:
  - Shift left.
  - Trial-subtract the divisor from the upper half.
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore.
- CALC exits to FIX after exactly 32 iterations (counter 0..31).
- FIX, multiply:
  - Negate the 64-bit product if signed and the result sign is 1.
  - Write hi/lo; done = 1 next cycle.
- FIX, divide:
  - Negate the quotient if the result sign is 1; negate the remainder if the remainder sign is 1 (signed only).
  - hi = remainder, lo = quotient.
- FIX, zero flag set: hi/lo unchanged, divzero = 1, done = 1.
- FIX always returns to IDLE.
- Arithmetic: all results are modulo 2^32 per word.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This falls out of the magnitude algorithm; no special case.
- start while busy = 1: ignored, no side effect. Operands are not re-sampled.

## Timing
- Reset values: busy = 0, done = 0, divzero = 0, hi = 0, lo = 0; state IDLE; counter 0.
- Reset mid-operation: the operation is aborted immediately and asynchronously. No done is produced. hi/lo return to 0.
- Accept edge E0 (start = 1 and IDLE). busy = 1 from E0 through the cycle before done.
- Normal op:
  - E1..E32: iterations.
  - E33: FIX registers the results; busy = 0 and done = 1 for the cycle after E33.
  - Latency from accept to done = 34 cycles.
- Divide-by-zero: FIX at E1; done = 1 and divzero = 1 for the cycle after E1 (latency 2).
- start = 1 in the done cycle is accepted, so back-to-back operations are allowed. hi/lo keep the old result until the new FIX.
- hi/lo change only at FIX or reset; they are stable otherwise.

## Structure
- Shared package cpu_pkg holds:
  - enum md_op_t {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  - enum md_state_t {MD_IDLE, MD_CALC, MD_FIX};
  - localparam MD_ITERS = 32.
- Single module, no sub-module. The datapath is a 64-bit shift register, a 33-bit adder/subtractor, and a 5-bit counter.

## Test plan
- MULT 7 × 0xFFFFFFFD (-3) -> done 34 cycles after accept; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 2 -> hi = 0x00000001, lo = 0xFFFFFFFE. Repeat as MULT -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 100 / 7 -> lo = 14, hi = 2.
- DIV 5 / 0 after a completed op -> done 2 cycles after accept; divzero = 1; hi/lo unchanged. The next accepted start clears divzero.
- Pulse start with different operands at cycles 5 and 20 of an op -> ignored; result matches the original operands. start held high in the done cycle -> second op accepted with no gap.
- Assert reset at iteration 15 -> busy, done, hi, lo all 0 immediately; no done pulse. A subsequent MULT 3 × 4 -> lo = 12, hi = 0.
